// File: rtl/fft_buf_pkg.sv
// Shared constants, state types and lane helpers for the
// 256-point FFT output buffer sequencer.
package fft_buf_pkg;

  localparam int ADDR_W    = 8;
  localparam int LANES     = 8;
  localparam int WR_CYCLES = 32;
  localparam int N_POINTS  = 1 << ADDR_W;
  localparam int HALF      = N_POINTS / 2;
  localparam int WCNT_W    = $clog2(WR_CYCLES);
  localparam int LANE_STEP = LANES / 2;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic {
    W_IDLE,
    W_ACTIVE
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_ACTIVE
  } rd_state_e;

  // Even lanes walk the low half, odd lanes the high half.
  function automatic addr_t lane_base(input int unsigned k);
    int unsigned b;
    b = (k >> 1) + HALF * (k & 1);
    return addr_t'(b);
  endfunction

endpackage

// File: rtl/fft_obuf_sequencer_if.sv
// Frame-start input and buffer control outputs of the
// FFT output buffer sequencer.
interface fft_obuf_sequencer_if;
  import fft_buf_pkg::*;

  logic                    startin;
  logic                    wr_en;
  logic                    wr_bank;
  logic [LANES*ADDR_W-1:0] wr_addr;
  logic                    rd_en;
  logic                    rd_bank;
  logic [ADDR_W-1:0]       rd_addr;
  logic                    out_valid;
  logic                    startout;
  logic                    busy;
  logic                    overrun;

  modport master (
    input  startin,
    output wr_en,
    output wr_bank,
    output wr_addr,
    output rd_en,
    output rd_bank,
    output rd_addr,
    output out_valid,
    output startout,
    output busy,
    output overrun
  );

  modport slave (
    output startin,
    input  wr_en,
    input  wr_bank,
    input  wr_addr,
    input  rd_en,
    input  rd_bank,
    input  rd_addr,
    input  out_valid,
    input  startout,
    input  busy,
    input  overrun
  );

endinterface

// File: rtl/fft_obuf_wr_addr_gen.sv
// Eight-lane digit-reversed write address generator;
// every lane advances by LANE_STEP per write cycle.
module fft_obuf_wr_addr_gen
  import fft_buf_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic                    step,
  input  logic                    clr,
  output logic [LANES*ADDR_W-1:0] wr_addr
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      wr_addr <= '0;
    end else if (load) begin
      for (int k = 0; k < LANES; k++)
        wr_addr[k*ADDR_W +: ADDR_W] <= lane_base(k);
    end else if (step) begin
      for (int k = 0; k < LANES; k++)
        wr_addr[k*ADDR_W +: ADDR_W] <=
          wr_addr[k*ADDR_W +: ADDR_W] + addr_t'(LANE_STEP);
    end
  end

endmodule

// File: rtl/fft_obuf_sequencer.sv
// Ping-pong FFT output buffer controller: lane writes,
// natural-order reads, framing and overrun flag.
module fft_obuf_sequencer
  import fft_buf_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  fft_obuf_sequencer_if.master bus
);

  wr_state_e         w_state;
  rd_state_e         r_state;
  logic [WCNT_W-1:0] wcnt;
  addr_t             rcnt;
  logic [1:0]        full;
  logic [1:0]        full_set;
  logic [1:0]        full_clr;
  logic              wr_bank_q;
  logic              rd_bank_q;
  logic              wr_en_q;
  logic              rd_en_q;
  logic              out_valid_q;
  logic              startout_q;
  logic              overrun_q;
  logic              accept;
  logic              reject;
  logic              wr_done;
  logic              rd_done;
  logic              rd_full_now;
  logic              oth_full_now;

  assign accept  = bus.startin && (w_state == W_IDLE)
                   && !full[wr_bank_q];
  assign reject  = bus.startin && !accept;
  assign wr_done = (w_state == W_ACTIVE)
                   && (wcnt == WCNT_W'(WR_CYCLES - 1));
  assign rd_done = (r_state == R_ACTIVE)
                   && (rcnt == addr_t'(N_POINTS - 1));

  // Look ahead at a completing write so reads start with no bubble.
  assign rd_full_now  = full[rd_bank_q]
                        || (wr_done && (wr_bank_q == rd_bank_q));
  assign oth_full_now = full[~rd_bank_q]
                        || (wr_done && (wr_bank_q != rd_bank_q));

  always_comb begin
    full_set = 2'b00;
    full_clr = 2'b00;
    if (wr_done) full_set[wr_bank_q] = 1'b1;
    if (rd_done) full_clr[rd_bank_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state   <= W_IDLE;
      wcnt      <= '0;
      wr_bank_q <= 1'b0;
      wr_en_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (reject) overrun_q <= 1'b1;
      unique case (w_state)
        W_IDLE: begin
          if (accept) begin
            w_state <= W_ACTIVE;
            wcnt    <= '0;
            wr_en_q <= 1'b1;
          end
        end
        W_ACTIVE: begin
          if (wr_done) begin
            w_state   <= W_IDLE;
            wr_en_q   <= 1'b0;
            wr_bank_q <= ~wr_bank_q;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= R_IDLE;
      rcnt      <= '0;
      rd_bank_q <= 1'b0;
      rd_en_q   <= 1'b0;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          if (rd_full_now) begin
            r_state <= R_ACTIVE;
            rcnt    <= '0;
            rd_en_q <= 1'b1;
          end
        end
        R_ACTIVE: begin
          if (rd_done) begin
            rcnt      <= '0;
            rd_bank_q <= ~rd_bank_q;
            if (!oth_full_now) begin
              r_state <= R_IDLE;
              rd_en_q <= 1'b0;
            end
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full        <= 2'b00;
      out_valid_q <= 1'b0;
      startout_q  <= 1'b0;
    end else begin
      full        <= (full & ~full_clr) | full_set;
      out_valid_q <= rd_en_q;
      startout_q  <= rd_en_q && (rcnt == '0);
    end
  end

  fft_obuf_wr_addr_gen u_wr_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .step    ((w_state == W_ACTIVE) && !wr_done),
    .clr     (wr_done),
    .wr_addr (bus.wr_addr)
  );

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_bank   = wr_bank_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_bank   = rd_bank_q;
  assign bus.rd_addr   = rcnt;
  assign bus.out_valid = out_valid_q;
  assign bus.startout  = startout_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = (w_state == W_ACTIVE)
                         || (r_state == R_ACTIVE)
                         || (|full);

endmodule

// File: tb/tb_fft_obuf_sequencer.sv
// Directed bench for the FFT output buffer sequencer:
// framing latency, ping-pong, overrun, reset and idle values.
module tb_fft_obuf_sequencer;
  import fft_buf_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;

  fft_obuf_sequencer_if bus ();

  fft_obuf_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc;
  int n_wr, first_wr, last_wr;
  int n_rd, first_rd, last_rd;
  int n_ov, first_ov, last_ov;
  int n_so, so0, so1;
  int dup, lane7_bad, rd_addr_bad, idle_bad;
  int busy_fall;
  logic prev_rd;
  logic [255:0] seen;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    cyc = 0;
    n_wr = 0; first_wr = -1; last_wr = -1;
    n_rd = 0; first_rd = -1; last_rd = -1;
    n_ov = 0; first_ov = -1; last_ov = -1;
    n_so = 0; so0 = -1; so1 = -1;
    dup = 0; lane7_bad = 0; rd_addr_bad = 0; idle_bad = 0;
    busy_fall = -1; prev_rd = 1'b0; seen = '0;
  endtask

  task automatic tick();
    int a;
    int j;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.wr_en) begin
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      j = n_wr % 32;
      if (int'(bus.wr_addr[63:56]) != ((131 + 4 * j) % 256))
        lane7_bad++;
      if (n_wr < 32) begin
        for (int k = 0; k < 8; k++) begin
          a = int'(bus.wr_addr[8*k +: 8]);
          if (seen[a]) dup++;
          seen[a] = 1'b1;
        end
      end
      n_wr++;
    end else if (bus.wr_addr != '0) begin
      idle_bad++;
    end
    if (bus.rd_en) begin
      if (first_rd < 0) first_rd = cyc;
      last_rd = cyc;
      if (int'(bus.rd_addr) != (n_rd % 256)) rd_addr_bad++;
      n_rd++;
    end else if (bus.rd_addr != '0) begin
      idle_bad++;
    end
    if (bus.out_valid) begin
      if (first_ov < 0) first_ov = cyc;
      last_ov = cyc;
      n_ov++;
    end
    if (bus.startout) begin
      if (n_so == 0) so0 = cyc;
      if (n_so == 1) so1 = cyc;
      n_so++;
    end
    if (prev_rd && !bus.rd_en) busy_fall = int'(bus.busy);
    prev_rd = bus.rd_en;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic pulse_at(input int c);
    run_to(c);
    bus.startin = 1'b1;
    tick();
    bus.startin = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.startin = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    clear_stats();
  endtask

  task automatic chk_all_zero(input string tag);
    int v;
    v = int'(bus.wr_en) + int'(bus.wr_bank) + int'(bus.rd_en)
      + int'(bus.rd_bank) + int'(bus.out_valid)
      + int'(bus.startout) + int'(bus.busy) + int'(bus.overrun)
      + int'(bus.rd_addr) + int'(|bus.wr_addr);
    chk(tag, v, 0);
  endtask

  initial begin
    bus.startin = 1'b0;
    clear_stats();

    // Reset state
    do_reset();
    chk_all_zero("reset_outputs");

    // Single frame
    pulse_at(10);
    run_to(100);
    chk("s1_busy_mid", int'(bus.busy), 1);
    run_to(305);
    chk("s1_first_wr", first_wr, 11);
    chk("s1_last_wr", last_wr, 42);
    chk("s1_n_wr", n_wr, 32);
    chk("s1_first_rd", first_rd, 43);
    chk("s1_last_rd", last_rd, 298);
    chk("s1_n_rd", n_rd, 256);
    chk("s1_first_ov", first_ov, 44);
    chk("s1_last_ov", last_ov, 299);
    chk("s1_n_so", n_so, 1);
    chk("s1_so0", so0, 44);
    chk("s1_cover", int'(&seen), 1);
    chk("s1_dup", dup, 0);
    chk("s1_lane7", lane7_bad, 0);
    chk("s1_rd_addr", rd_addr_bad, 0);
    chk("s1_idle_addr", idle_bad, 0);
    chk("s1_busy_fall", busy_fall, 0);
    chk("s1_overrun", int'(bus.overrun), 0);

    // Back-to-back frames
    do_reset();
    pulse_at(10);
    pulse_at(50);
    run_to(60);
    chk("s2_wr_en_60", int'(bus.wr_en), 1);
    chk("s2_wr_bank_60", int'(bus.wr_bank), 1);
    run_to(400);
    chk("s2_rd_bank_400", int'(bus.rd_bank), 1);
    run_to(560);
    chk("s2_n_wr", n_wr, 64);
    chk("s2_last_wr", last_wr, 82);
    chk("s2_first_rd", first_rd, 43);
    chk("s2_last_rd", last_rd, 554);
    chk("s2_n_rd", n_rd, 512);
    chk("s2_n_so", n_so, 2);
    chk("s2_so0", so0, 44);
    chk("s2_so1", so1, 300);
    chk("s2_rd_addr", rd_addr_bad, 0);
    chk("s2_lane7", lane7_bad, 0);
    chk("s2_busy_fall", busy_fall, 0);
    chk("s2_overrun", int'(bus.overrun), 0);

    // Both banks full: third start rejected
    do_reset();
    pulse_at(10);
    pulse_at(50);
    run_to(99);
    chk("s3_overrun_pre", int'(bus.overrun), 0);
    pulse_at(100);
    chk("s3_overrun", int'(bus.overrun), 1);
    chk("s3_wr_en_101", int'(bus.wr_en), 0);
    chk("s3_n_wr_101", n_wr, 64);
    pulse_at(300);
    chk("s3_wr_en_301", int'(bus.wr_en), 1);
    chk("s3_wr_bank_301", int'(bus.wr_bank), 0);
    run_to(340);
    chk("s3_n_wr", n_wr, 96);
    chk("s3_overrun_sticky", int'(bus.overrun), 1);

    // Start during write
    do_reset();
    pulse_at(10);
    pulse_at(20);
    chk("s4_overrun", int'(bus.overrun), 1);
    run_to(60);
    chk("s4_n_wr", n_wr, 32);
    chk("s4_last_wr", last_wr, 42);

    // Reset mid-read, then a fresh frame
    do_reset();
    pulse_at(10);
    run_to(150);
    chk("s5_rd_en_150", int'(bus.rd_en), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_all_zero("s5_after_reset");
    clear_stats();
    pulse_at(10);
    run_to(305);
    chk("s5_first_wr", first_wr, 11);
    chk("s5_first_rd", first_rd, 43);
    chk("s5_last_rd", last_rd, 298);
    chk("s5_so0", so0, 44);
    chk("s5_n_so", n_so, 1);
    chk("s5_rd_addr", rd_addr_bad, 0);
    chk("s5_busy_end", int'(bus.busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
